lfsr_seeded: RTL and testbench



---
 rtl/lfsr_pkg.sv | 16 +
 rtl/lfsr_seeded.sv | 50 +++++
 tb/tb_lfsr_seeded.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/lfsr_pkg.sv
// Shared constants and the feedback helper for the seedable Fibonacci LFSR.
package lfsr_pkg;

   localparam int          LFSR_DEFAULT_WIDTH = 8;
   localparam logic [7:0]  LFSR_DEFAULT_TAPS  = 8'hB8;
   localparam logic [7:0]  LFSR_DEFAULT_RESET = 8'h01;

   // Widest register the feedback helper accepts; callers zero-extend.
   localparam int          LFSR_MAX_WIDTH     = 64;

   function automatic logic lfsr_feedback(input logic [LFSR_MAX_WIDTH-1:0] state,
                                          input logic [LFSR_MAX_WIDTH-1:0] taps);
      return ^(state & taps);
   endfunction

endpackage

// File: rtl/lfsr_seeded.sv
// Seedable Fibonacci LFSR emitting one pseudo-random bit per clock.
// Optional macro LFSR_STATE_OUT_EN exposes the full register as state_out.
module lfsr_seeded
   import lfsr_pkg::*;
#(
   parameter int              WIDTH       = LFSR_DEFAULT_WIDTH,
   parameter logic [WIDTH-1:0] TAPS        = WIDTH'(LFSR_DEFAULT_TAPS),
   parameter logic [WIDTH-1:0] RESET_STATE = WIDTH'(LFSR_DEFAULT_RESET)
) (
   input  logic             clk,
   input  logic             clr,
   input  logic [WIDTH-1:0] seed,
   input  logic             select,
`ifdef LFSR_STATE_OUT_EN
   output logic [WIDTH-1:0] state_out,
`endif
   output logic             out
);

   logic [WIDTH-1:0] state_q;
   logic [WIDTH-1:0] state_d;
   logic             fb;

   assign fb = lfsr_feedback(LFSR_MAX_WIDTH'(state_q), LFSR_MAX_WIDTH'(TAPS));

   always_comb begin
      // NOTE: default assigned first so no path leaves state_d unassigned (no latch).
      state_d = {state_q[WIDTH-2:0], fb};
      if (select) begin
         // A zero seed would lock the register; substitute the reset value.
         state_d = (seed != '0) ? seed : RESET_STATE;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignment for registered state.
      if (clr) begin
         state_q <= RESET_STATE;
      end else begin
         state_q <= state_d;
      end
   end

   assign out = state_q[WIDTH-1];

`ifdef LFSR_STATE_OUT_EN
   assign state_out = state_q;
`endif

endmodule

// File: tb/tb_lfsr_seeded.sv
// Self-checking bench for lfsr_seeded: behavioural model, literal pins, directed and random stimulus.
module tb_lfsr_seeded;
   import lfsr_pkg::*;

   localparam logic [7:0] TAPS = 8'hB8;
   localparam logic [7:0] RST  = 8'h01;

   logic       clk = 1'b0;
   logic       clr = 1'b0;
   logic       select = 1'b0;
   logic [7:0] seed = 8'h00;
   logic       out;
   logic [7:0] dut_state;

`ifdef LFSR_STATE_OUT_EN
   logic [7:0] state_out;
   assign dut_state = state_out;
`else
   assign dut_state = dut.state_q;
`endif

   lfsr_seeded dut (
      .clk       (clk),
      .clr       (clr),
      .seed      (seed),
      .select    (select),
`ifdef LFSR_STATE_OUT_EN
      .state_out (state_out),
`endif
      .out       (out)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference rule: reset wins, then load (zero seed -> reset value),
   // otherwise multiply by two mod 256 and add the parity of the tapped bits.
   function automatic logic [7:0] ref_next(input logic [7:0] s, input logic c,
                                           input logic sel, input logic [7:0] sd);
      int parity;
      if (c) return RST;
      if (sel) return (sd == 8'h00) ? RST : sd;
      parity = $countones(s & TAPS) % 2;
      return 8'((int'(s) * 2) % 256 + parity);
   endfunction

   logic [7:0] model_state = 8'h00;
   bit         model_valid = 1'b0;

   always @(posedge clk) begin
      if (clr) model_valid = 1'b1;
      if (model_valid) model_state = ref_next(model_state, clr, select, seed);
   end

   always @(negedge clk) begin
      if (model_valid) begin
         check("cmp_out", 32'(out), 32'(model_state[7]));
         check("cmp_state", 32'(dut_state), 32'(model_state));
         check("cmp_nonzero", 32'(dut_state != 8'h00), 32'd1);
      end
   end

   // Starts and ends on a falling edge, so the next edge applies these inputs.
   task automatic tick(input logic c, input logic sel, input logic [7:0] sd);
      clr = c; select = sel; seed = sd;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic pin(input string name, input logic [7:0] exp);
      check({name, "_state"}, 32'(dut_state), 32'(exp));
      check({name, "_out"}, 32'(out), 32'(exp[7]));
      check({name, "_model"}, 32'(model_state), 32'(exp));
   endtask

   initial begin
      logic [7:0] seq [0:6];
      bit         seen [256];
      int         distinct, ones, first_ret;

      @(negedge clk);

      // Reset and first shifts
      tick(1'b1, 1'b0, 8'h00);
      pin("reset", 8'h01);
      tick(1'b0, 1'b0, 8'h00); pin("rst_shift1", 8'h02);
      tick(1'b0, 1'b0, 8'h00); pin("rst_shift2", 8'h04);
      tick(1'b0, 1'b0, 8'h00); pin("rst_shift3", 8'h08);
      tick(1'b0, 1'b0, 8'h00); pin("rst_shift4", 8'h11);

      // Seed load of 01 and the following sequence
      seq = '{8'h02, 8'h04, 8'h08, 8'h11, 8'h23, 8'h47, 8'h8E};
      tick(1'b0, 1'b1, 8'h01); pin("load01", 8'h01);
      for (int i = 0; i < 7; i++) begin
         tick(1'b0, 1'b0, 8'h00);
         pin($sformatf("seq%0d", i), seq[i]);
      end

      // Zero seed guard
      tick(1'b0, 1'b1, 8'h00); pin("zero_seed", 8'h01);
      tick(1'b0, 1'b0, 8'h00); pin("zero_seed_shift", 8'h02);

      // Priority: clr over select
      tick(1'b1, 1'b1, 8'hA5); pin("prio_clr", 8'h01);
      tick(1'b0, 1'b1, 8'hA5); pin("prio_load", 8'hA5);

      // Full period
      tick(1'b0, 1'b1, 8'h01);
      foreach (seen[i]) seen[i] = 1'b0;
      distinct = 0; ones = 0; first_ret = -1;
      for (int i = 1; i <= 255; i++) begin
         tick(1'b0, 1'b0, 8'h00);
         if (!seen[dut_state]) distinct++;
         seen[dut_state] = 1'b1;
         ones += int'(out);
         if (dut_state == 8'h01 && first_ret < 0) first_ret = i;
      end
      check("period_return", 32'(first_ret), 32'd255);
      check("period_distinct", 32'(distinct), 32'd255);
      check("period_ones", 32'(ones), 32'd128);
      check("period_no_zero", 32'(seen[0]), 32'd0);

      // Hold load
      for (int i = 0; i < 5; i++) begin
         tick(1'b0, 1'b1, 8'h80);
         pin($sformatf("hold%0d", i), 8'h80);
      end
      tick(1'b0, 1'b0, 8'h00); pin("hold_release", 8'h01);

      // Random traffic checked by the compare process
      for (int i = 0; i < 600; i++) begin
         logic       c, s;
         logic [7:0] sd;
         c  = ($urandom_range(0, 31) == 0);
         s  = ($urandom_range(0, 7) == 0);
         sd = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
         tick(c, s, sd);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
